// File: rtl/gf180mcu_fd_sc_mcu7t5v0__orn_pkg.sv
// Shared constants and helpers for the pipelined N-input OR: tree depth math
// and the output-stage mode encoding.
package gf180mcu_fd_sc_mcu7t5v0__orn_pkg;

  typedef enum logic {
    MODE_PLAIN  = 1'b0,
    MODE_STICKY = 1'b1
  } mode_e;

  // Smallest l with 3**l >= n.
  function automatic int clog3(input int n);
    int l;
    int p;
    l = 0;
    p = 1;
    while (p < n) begin
      p = p * 3;
      l = l + 1;
    end
    return l;
  endfunction

  // Registered tree depth; a single level is always present.
  function automatic int levels(input int n);
    return (clog3(n) < 1) ? 1 : clog3(n);
  endfunction

  // Operand count per channel entering tree level l.
  function automatic int lvl_cnt(input int n, input int l);
    int c;
    c = n;
    for (int i = 0; i < l; i++) c = (c + 2) / 3;
    return c;
  endfunction

  localparam int NUM_IN_DEF = 3;
  localparam int LEVELS     = levels(NUM_IN_DEF);
  localparam int LEVELS_MAX = levels(81);

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__or3_stage.sv
// One radix-3 OR tree level: groups of three operands per channel are ORed.
// REG=0 leaves the level combinational so the consumer's register closes it.
module gf180mcu_fd_sc_mcu7t5v0__or3_stage #(
  parameter int N_IN  = 3,
  parameter int WIDTH = 1,
  parameter int REG   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              vi,
  input  logic [N_IN*WIDTH-1:0]             d,
  output logic                              vo,
  output logic [((N_IN+2)/3)*WIDTH-1:0]     q
);

  localparam int N_OUT = (N_IN + 2) / 3;

  logic [N_OUT*WIDTH-1:0] or_nxt;

  // Missing leaves of the last group simply never contribute (zero padding).
  always_comb begin
    or_nxt = '0;
    for (int k = 0; k < N_IN; k++)
      or_nxt[(k/3)*WIDTH +: WIDTH] = or_nxt[(k/3)*WIDTH +: WIDTH] | d[k*WIDTH +: WIDTH];
  end

  if (REG != 0) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) vo <= 1'b0;
      else     vo <= vi;
    end

    // Data is gated by valid and intentionally left unreset.
    always_ff @(posedge clk) begin
      if (vi) q <= or_nxt;
    end
  end else begin : g_comb
    wire unused_clk;
    assign unused_clk = clk | rst;
    assign vo = vi;
    assign q  = or_nxt;
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__orn_pipe.sv
// Pipelined NUM_IN-operand OR per channel with plain/sticky output, sync clear
// and a saturating count of nonzero output beats.
module gf180mcu_fd_sc_mcu7t5v0__orn_pipe
  import gf180mcu_fd_sc_mcu7t5v0__orn_pkg::*;
#(
  parameter int NUM_IN = 3,
  parameter int WIDTH  = 1,
  parameter int HIT_W  = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_IN*WIDTH-1:0] A,
  input  logic                    VLD_I,
  input  logic                    MODE,
  input  logic                    CLR,
  output logic [WIDTH-1:0]        Z,
  output logic                    VLD_O,
  output logic [HIT_W-1:0]        HITS,
  inout  wire                     VDD,
  inout  wire                     VSS
);

  localparam int LVLS = levels(NUM_IN);

  logic [LVLS:0]      vld_pipe;
  logic [WIDTH-1:0]   tree;
  logic               beat;
  logic [WIDTH-1:0]   z_nxt;
  logic [HIT_W-1:0]   h_nxt;

  wire unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  assign vld_pipe[0] = VLD_I;

  // The last level is combinational; the Z register is its pipeline register.
  for (genvar l = 0; l < LVLS; l++) begin : lv
    localparam int NI = lvl_cnt(NUM_IN, l);
    localparam int NO = lvl_cnt(NUM_IN, l + 1);

    logic [NI*WIDTH-1:0] d;
    logic [NO*WIDTH-1:0] q;

    if (l == 0) begin : g_first
      assign d = A;
    end else begin : g_next
      assign d = lv[l-1].q;
    end

    gf180mcu_fd_sc_mcu7t5v0__or3_stage #(
      .N_IN  (NI),
      .WIDTH (WIDTH),
      .REG   ((l < LVLS - 1) ? 1 : 0)
    ) u_stage (
      .clk (CLK),
      .rst (RST),
      .vi  (vld_pipe[l]),
      .d   (d),
      .vo  (vld_pipe[l+1]),
      .q   (q)
    );
  end

  assign tree = lv[LVLS-1].q;
  assign beat = vld_pipe[LVLS];

  // Clear first, then let a coincident beat accumulate into the cleared state.
  always_comb begin
    z_nxt = Z;
    h_nxt = HITS;
    if (CLR) begin
      z_nxt = '0;
      h_nxt = '0;
    end
    if (beat) begin
      z_nxt = ((mode_e'(MODE) == MODE_STICKY) ? z_nxt : '0) | tree;
      if ((|tree) && (h_nxt != {HIT_W{1'b1}}))
        h_nxt = h_nxt + HIT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Z     <= '0;
      VLD_O <= 1'b0;
      HITS  <= '0;
    end else begin
      Z     <= z_nxt;
      VLD_O <= beat;
      HITS  <= h_nxt;
    end
  end

endmodule
